multi_mode_counter_bank: RTL and testbench
==========================================

Name: multi_mode_counter_bank

Overview:
- Parametrised successor to the single free-running 32-bit cycle counter: a bank of NUM_CH independent counters with per-channel enable, synchronous load, up/down direction, programmable terminal limit and wrap/saturate mode.
- Each channel produces a one-cycle terminal-count (TC) pulse and a sticky overflow flag.
- Used as the shared event/timeout counter resource in the benchmark designs.
- Single clock domain; no combinational path from inputs to outputs.

Parameters:
- WIDTH, 32, counter width in bits (≥2).
- NUM_CH, 4, number of independent channels (≥1).
- RST_VAL, 0, value loaded into every counter on reset (< 2^WIDTH).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- en  in  NUM_CH  per-channel count enable.
- load  in  NUM_CH  per-channel synchronous load strobe.
- load_val  in  NUM_CH*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH].
- limit  in  NUM_CH*WIDTH  terminal value per channel, same packing.
- dir  in  NUM_CH  1 = count down, 0 = count up.
- sat  in  NUM_CH  1 = saturate at terminal, 0 = wrap.
- ovf_clr  in  NUM_CH  clears the sticky overflow flag.
- count  out  NUM_CH*WIDTH  registered counter values, same packing.
- tc  out  NUM_CH  registered one-cycle terminal-count pulse.
- ovf  out  NUM_CH  sticky overflow flag.
- any_tc  out  1  registered OR of next-cycle tc bits; equals |tc in the same cycle.

Behaviour:
- Reset (RST=1 at an edge): every count = RST_VAL, tc = 0, ovf = 0, any_tc = 0. Reset overrides all other inputs, including a reset asserted mid-count or during a load.
- Per-channel priority at each edge: RST > load > en > hold.
- load=1: count <= load_val[i], taken verbatim (no clamping to limit). tc <= 0. en is ignored that cycle.
- Terminal condition (T):
  - Up (dir=0): count >= limit.
  - Down (dir=1): count == 0.
- en=1, load=0, not T:
  - Up: count <= count+1.
  - Down: count <= count-1.
  - tc <= 0.
- en=1, load=0, T:
  - tc <= 1 and ovf <= 1.
  - Wrap, up: count <= 0.
  - Wrap, down: count <= limit.
  - Saturate: count holds. tc pulses on every enabled cycle while held at the terminal.
- en=0, load=0: count holds, tc <= 0.
- limit = 0, up: T is always true. Wrap holds 0 and pulses tc every enabled cycle; saturate holds.
- limit = 2^WIDTH-1, up, wrap: counts the full range; 2^WIDTH-1 -> 0 with tc. No arithmetic overflow path exists outside T.
- dir or sat changing mid-count: takes effect at the next edge. State is only count and the flags; no history is kept.
- Latency: count and tc reflect the inputs sampled at edge N from edge N onward (one register stage). any_tc is computed from the next-state tc values, so it is coincident with tc.
- ovf:
  - Set when tc is set.
  - Cleared by ovf_clr at the next edge.
  - If set and clear hit the same edge, set wins.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Implementation: generate loop over channels; arithmetic modulo 2^WIDTH.

Test Plan:
- Reset then count: RST=1 for 2 cycles, then en[0]=1, dir=0, sat=0, limit=5. Expect count0 sequence 0,1,2,3,4,5,0; tc[0]=1 only in the cycle count0 returns to 0; ovf[0]=1 from then on; any_tc=1 in that same cycle.
- Down-wrap and saturate (ch1): load_val=3, load=1, then dir=1, sat=0, limit=7. Expect 3,2,1,0,7 with tc on the 0->7 step. Repeat with sat=1: expect 3,2,1,0,0,0 with tc high on every cycle at 0 while en=1.
- Load priority and out-of-range load (ch2): en=1 and load=1 with load_val=100, limit=10, up. Expect count=100, tc=0 after the load edge. Next enabled edge: T true (100 >= 10), so count=0 and tc=1 (wrap).
- Independence: all four channels enabled with different limits (2,3,4,5), up, wrap, for 60 cycles. Expect tc[i] period = limit+1 (3,4,5,6 cycles). any_tc equals the OR of tc every cycle.
- Flag race: assert ovf_clr[0] on the same edge tc[0] sets. Expect ovf[0]=1. ovf_clr alone on a later edge gives ovf[0]=0.
- Mid-operation reset: RST pulsed while count0=4, load[1]=1 and tc[2]=1 are all pending. Expect all counts = RST_VAL and all tc/ovf/any_tc = 0 on the next cycle.

Source files
------------

// File: rtl/multi_mode_counter_bank.sv
// Bank of NUM_CH independent up/down counters with per-channel load, terminal
// limit, wrap/saturate mode, one-cycle terminal-count pulse and sticky overflow flag.
module multi_mode_counter_bank #(
    parameter int                WIDTH   = 32,
    parameter int                NUM_CH  = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_CH-1:0]        en,
    input  logic [NUM_CH-1:0]        load,
    input  logic [NUM_CH*WIDTH-1:0]  load_val,
    input  logic [NUM_CH*WIDTH-1:0]  limit,
    input  logic [NUM_CH-1:0]        dir,
    input  logic [NUM_CH-1:0]        sat,
    input  logic [NUM_CH-1:0]        ovf_clr,
    output logic [NUM_CH*WIDTH-1:0]  count,
    output logic [NUM_CH-1:0]        tc,
    output logic [NUM_CH-1:0]        ovf,
    output logic                     any_tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [NUM_CH-1:0] tc_next;
    logic              any_tc_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] count_reg;
            logic [WIDTH-1:0] count_next;
            logic [WIDTH-1:0] lim;
            logic [WIDTH-1:0] ld;
            logic             tc_reg;
            logic             tc_ch_next;
            logic             ovf_reg;
            logic             ovf_next;
            logic             term;

            assign lim  = limit[gi*WIDTH +: WIDTH];
            assign ld   = load_val[gi*WIDTH +: WIDTH];
            // Up uses >= so an out-of-range loaded value still terminates instead of running away.
            assign term = dir[gi] ? (count_reg == '0) : (count_reg >= lim);

            always_comb begin
                count_next = count_reg;
                tc_ch_next = 1'b0;
                if (load[gi]) begin
                    count_next = ld;
                end else if (en[gi]) begin
                    if (term) begin
                        tc_ch_next = 1'b1;
                        if (!sat[gi]) begin
                            count_next = dir[gi] ? lim : '0;
                        end
                    end else begin
                        count_next = dir[gi] ? (count_reg - ONE) : (count_reg + ONE);
                    end
                end
            end

            // A new terminal event beats a simultaneous clear.
            assign ovf_next    = tc_ch_next | (ovf_reg & ~ovf_clr[gi]);
            assign tc_next[gi] = tc_ch_next;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    count_reg <= RST_VAL;
                    tc_reg    <= 1'b0;
                    ovf_reg   <= 1'b0;
                end else begin
                    count_reg <= count_next;
                    tc_reg    <= tc_ch_next;
                    ovf_reg   <= ovf_next;
                end
            end

            assign count[gi*WIDTH +: WIDTH] = count_reg;
            assign tc[gi]                   = tc_reg;
            assign ovf[gi]                  = ovf_reg;
        end
    endgenerate

    // Registered from next-state tc so it lines up with tc rather than lagging it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            any_tc_reg <= 1'b0;
        end else begin
            any_tc_reg <= |tc_next;
        end
    end

    assign any_tc = any_tc_reg;

endmodule

// File: tb/tb_multi_mode_counter_bank.sv
// Scoreboard bench for multi_mode_counter_bank: stimulus pushes hand-derived
// expectations per edge, a negedge monitor pops and compares them.
module tb_multi_mode_counter_bank;

    localparam int W  = 8;
    localparam int NC = 4;

    logic              CLK;
    logic              RST;
    logic [NC-1:0]     en;
    logic [NC-1:0]     load;
    logic [NC*W-1:0]   load_val;
    logic [NC*W-1:0]   limit;
    logic [NC-1:0]     dir;
    logic [NC-1:0]     sat;
    logic [NC-1:0]     ovf_clr;
    logic [NC*W-1:0]   count;
    logic [NC-1:0]     tc;
    logic [NC-1:0]     ovf;
    logic              any_tc;

    multi_mode_counter_bank #(
        .WIDTH   (W),
        .NUM_CH  (NC),
        .RST_VAL ('0)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .dir      (dir),
        .sat      (sat),
        .ovf_clr  (ovf_clr),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf),
        .any_tc   (any_tc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string name;
        int    kind;   // 0 count[ch], 1 tc vector, 2 ovf vector, 3 any_tc
        int    ch;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input string name, input int kind, input int ch, input int val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.ch   = ch;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic expect_all(input string name, input int c0, input int c1, input int c2,
                              input int c3, input int tcv, input int ovfv);
        push(name, 0, 0, c0);
        push(name, 0, 1, c1);
        push(name, 0, 2, c2);
        push(name, 0, 3, c3);
        push(name, 1, 0, tcv);
        push(name, 2, 0, ovfv);
        push(name, 3, 0, (tcv != 0) ? 1 : 0);
        $display("txn %s: count=%0d,%0d,%0d,%0d tc=%b ovf=%b", name, c0, c1, c2, c3,
                 tcv[NC-1:0], ovfv[NC-1:0]);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lv(input int ch, input int v);
        load_val[ch*W +: W] = W'(v);
    endtask

    task automatic set_lim(input int ch, input int v);
        limit[ch*W +: W] = W'(v);
    endtask

    // Monitor: outputs are stable at the falling edge.
    exp_t m_e;
    int   m_act;
    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            case (m_e.kind)
                0:       m_act = int'(count[m_e.ch*W +: W]);
                1:       m_act = int'(tc);
                2:       m_act = int'(ovf);
                default: m_act = int'(any_tc);
            endcase
            checks++;
            if (m_act != m_e.val) begin
                failures++;
                $display("FAIL %s kind=%0d ch=%0d actual=%0d required=%0d",
                         m_e.name, m_e.kind, m_e.ch, m_act, m_e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c[NC];
        int tcv;
        int ovfv;
        int lim_i;

        RST = 1'b1; en = '0; load = '0; load_val = '0; limit = '0;
        dir = '0; sat = '0; ovf_clr = '0;

        // Reset held two cycles
        tick();
        tick();
        expect_all("reset", 0, 0, 0, 0, 0, 0);

        // Channel 0: up, wrap, limit 5
        RST = 1'b0;
        en[0] = 1'b1;
        set_lim(0, 5);
        for (int k = 1; k <= 6; k++) begin
            tick();
            expect_all($sformatf("up_wrap k=%0d", k), (k == 6) ? 0 : k, 0, 0, 0,
                       (k == 6) ? 1 : 0, (k == 6) ? 1 : 0);
        end
        en[0] = 1'b0;
        tick();
        expect_all("up_wrap idle", 0, 0, 0, 0, 0, 1);

        // Channel 1: down, wrap, limit 7, load 3 (en also high)
        en[1] = 1'b1; dir[1] = 1'b1; set_lim(1, 7); load[1] = 1'b1; set_lv(1, 3);
        tick();
        expect_all("dn_wrap load", 0, 3, 0, 0, 0, 1);
        load[1] = 1'b0;
        tick(); expect_all("dn_wrap k=1", 0, 2, 0, 0, 0, 1);
        tick(); expect_all("dn_wrap k=2", 0, 1, 0, 0, 0, 1);
        tick(); expect_all("dn_wrap k=3", 0, 0, 0, 0, 0, 1);
        tick(); expect_all("dn_wrap k=4", 0, 7, 0, 0, 2, 3);

        // Channel 1: down, saturate
        load[1] = 1'b1; sat[1] = 1'b1;
        tick();
        expect_all("dn_sat load", 0, 3, 0, 0, 0, 3);
        load[1] = 1'b0;
        tick(); expect_all("dn_sat k=1", 0, 2, 0, 0, 0, 3);
        tick(); expect_all("dn_sat k=2", 0, 1, 0, 0, 0, 3);
        tick(); expect_all("dn_sat k=3", 0, 0, 0, 0, 0, 3);
        tick(); expect_all("dn_sat k=4", 0, 0, 0, 0, 2, 3);
        tick(); expect_all("dn_sat k=5", 0, 0, 0, 0, 2, 3);
        en[1] = 1'b0;
        tick(); expect_all("dn_sat idle", 0, 0, 0, 0, 0, 3);

        // Channel 2: load beats en, out-of-range value, then wraps
        en[2] = 1'b1; load[2] = 1'b1; set_lv(2, 100); set_lim(2, 10);
        tick(); expect_all("ld_prio load", 0, 0, 100, 0, 0, 3);
        load[2] = 1'b0;
        tick(); expect_all("ld_prio wrap", 0, 0, 0, 0, 4, 7);
        en[2] = 1'b0;

        // Flag race on channel 0
        ovf_clr[0] = 1'b1;
        tick(); expect_all("ovf_clr alone", 0, 0, 0, 0, 0, 6);
        ovf_clr[0] = 1'b0; load[0] = 1'b1; set_lv(0, 5);
        tick(); expect_all("race setup", 5, 0, 0, 0, 0, 6);
        load[0] = 1'b0; en[0] = 1'b1; ovf_clr[0] = 1'b1;
        tick(); expect_all("race set_wins", 0, 0, 0, 0, 1, 7);
        en[0] = 1'b0;
        tick(); expect_all("race clr_after", 0, 0, 0, 0, 0, 6);
        ovf_clr[0] = 1'b0;

        // Independence: limits 2,3,4,5, all up/wrap
        dir = '0; sat = '0; load = '1; load_val = '0; ovf_clr = '1;
        tick(); expect_all("indep clear", 0, 0, 0, 0, 0, 0);
        load = '0; ovf_clr = '0; en = '1;
        for (int i = 0; i < NC; i++) set_lim(i, i + 2);
        for (int k = 1; k <= 60; k++) begin
            tick();
            tcv  = 0;
            ovfv = 0;
            for (int i = 0; i < NC; i++) begin
                lim_i = i + 2;
                c[i] = k % (lim_i + 1);
                if (c[i] == 0) tcv = tcv | (1 << i);
                if (k >= lim_i + 1) ovfv = ovfv | (1 << i);
            end
            expect_all($sformatf("indep k=%0d", k), c[0], c[1], c[2], c[3], tcv, ovfv);
        end

        // Channel 3: limit 0, wrap holds 0 and pulses
        en = 4'b1000; set_lim(3, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            expect_all($sformatf("lim0 wrap k=%0d", k), 0, 0, 0, 0, 8, 15);
        end
        // limit 0, saturate, above-limit value holds
        sat[3] = 1'b1; load[3] = 1'b1; set_lv(3, 7);
        tick(); expect_all("lim0 sat load", 0, 0, 0, 7, 0, 15);
        load[3] = 1'b0;
        tick(); expect_all("lim0 sat k=1", 0, 0, 0, 7, 8, 15);
        tick(); expect_all("lim0 sat k=2", 0, 0, 0, 7, 8, 15);

        // Full-range wrap: 255 -> 0
        sat[3] = 1'b0; set_lim(3, 255); load[3] = 1'b1; set_lv(3, 253);
        tick(); expect_all("full load", 0, 0, 0, 253, 0, 15);
        load[3] = 1'b0;
        tick(); expect_all("full k=1", 0, 0, 0, 254, 0, 15);
        tick(); expect_all("full k=2", 0, 0, 0, 255, 0, 15);
        tick(); expect_all("full k=3", 0, 0, 0, 0, 8, 15);

        // Mid-operation reset with pending count, load and tc
        en = '0; load = 4'b0101; set_lv(0, 4); set_lv(2, 10); set_lim(2, 10);
        tick(); expect_all("midrst setup", 4, 0, 10, 0, 0, 15);
        RST = 1'b1; en = 4'b0101; load = 4'b0010; set_lv(1, 50);
        tick(); expect_all("midrst", 0, 0, 0, 0, 0, 0);
        RST = 1'b0; en = '0; load = '0;
        tick(); expect_all("post rst", 0, 0, 0, 0, 0, 0);

        @(negedge CLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
